axil_ctrl_regs: RTL and testbench
=================================

# axil_ctrl_regs

AXI-Lite control/status register file that terminates the OCL BAR0 AXI-Lite channel after the shell-side register slice. It is the core stage inside the custom logic's top level, and drives the virtual LEDs and reads back the virtual DIP switches. It also provides an ID word, a free-running cycle counter and host-writable scratch registers for bring-up and driver testing. Only single-beat 32-bit accesses are supported.

## Interface

- NUM_SCRATCH, 4: number of 32-bit scratch registers (1..8).
- ID_VALUE, 32'hC0DE_0001: constant returned by the ID register.

- clk_main_a0  in  1  sole clock.
- rst_main_n  in  1  asynchronous, active-low reset; deassertion already synchronized to clk_main_a0 by the parent.
- awvalid / awready / awaddr  in / out / in  1 / 1 / 32  write address channel.
- wvalid / wready / wdata / wstrb  in / out / in / in  1 / 1 / 32 / 4  write data channel.
- bvalid / bready / bresp  out / in / out  1 / 1 / 2  write response channel.
- arvalid / arready / araddr  in / out / in  1 / 1 / 32  read address channel.
- rvalid / rready / rresp / rdata  out / in / out / out  1 / 1 / 2 / 32  read data channel.
- vdip  in  16  virtual DIP switches, already synchronized to clk_main_a0.
- vled  out  16  virtual LEDs; registered copy of VLED[15:0].

## Operation

- Decode uses addr[7:2]. addr[1:0] are ignored. addr[31:8] != 0 counts as an unmapped address.
- Register map:
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 VLED: RW, bits [15:0]; upper bits read 0.
  - 0x08 VDIP: RO, {16'h0, vdip}.
  - 0x0C CYCLE: RO, 32-bit counter. Increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - 0x10 CTRL: WO. Writing bit0=1 zeroes CYCLE at the commit edge. Reads return 0.
  - 0x20 + 4*i, for i < NUM_SCRATCH: SCRATCH[i], RW.
- Byte strobes:
  - Writes to VLED and SCRATCH honour wstrb per byte.
  - CTRL acts only if wstrb[0]=1.
  - Writes to RO registers are ignored, with bresp=OKAY.
- Unmapped read: rdata=0, rresp=2'b10 (SLVERR).
- Unmapped write: no side effect, bresp=2'b10.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AW and W are accepted independently. awready=1 until an address is held; wready=1 until data is held.
  - Once both are held, the write commits on that edge and the FSM moves to W_RESP.
  - W_RESP: bvalid=1 and awready=wready=0. On bvalid&&bready, return to W_IDLE and clear the held flags.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready=1. On arvalid, rdata/rresp are captured from current register state and the FSM moves to R_RESP.
  - R_RESP: rvalid=1 and arready=0. rdata/rresp are stable until rvalid&&rready, then return to R_IDLE.
- The read and write paths are fully independent. Both may handshake in the same cycle.

## Timing

- Reset values (asynchronous): awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, vled=0, VLED=0, SCRATCH=0, CYCLE=0, both FSMs idle.
- awready, wready and arready are flops. They rise on the first clk_main_a0 edge after rst_main_n deasserts.
- Write latency: bvalid rises the cycle after the later of the AW/W handshakes. With AW and W presented together, the handshake is in cycle N and bvalid is in N+1.
- Read latency: an AR handshake in cycle N gives rvalid in N+1.
- Minimum spacing:
  - Back-to-back writes: one per 2 cycles when bready is held high.
  - Back-to-back reads: one per 2 cycles when rready is held high.
- vled reflects VLED one cycle after the commit edge.
- Read and write to the same register, with the AR handshake on the commit edge: the read returns the old value.
- CYCLE read on the same edge as a CTRL clear: the read returns the pre-clear value. On the following cycle CYCLE=0, then it increments.
- Ready gating:
  - awready drops the cycle after the AW handshake even if W has not yet arrived.
  - A second AW is not accepted until the response completes.
  - The same holds for wready.
- Reset mid-transaction: all state returns to reset values immediately. A pending response is dropped and the held AW/W are discarded.

## Test plan

- Reset, then read 0x00: rdata=ID_VALUE, rresp=0, rvalid exactly one cycle after the AR handshake.
- Write 0x04 with data 0x1234_ABCD, wstrb=4'b0011:
  - bresp=0 one cycle after the handshake.
  - vled=16'hABCD the cycle after commit.
  - Readback of 0x04 = 0x0000_ABCD.
- AW presented 3 cycles before W, and bready held low for 4 cycles:
  - awready is low after the AW handshake.
  - Exactly one write commits.
  - bvalid stays high until bready rises.
- Write 0xFFFF_FFFF to SCRATCH[1] with wstrb=4'b0101: readback = 0x00FF_00FF. Read 0x3C (unmapped) gives rdata=0, rresp=2'b10.
- Read CYCLE twice, 10 cycles apart: the difference equals the cycle spacing. Write CTRL=1, then read: the value is below 5. Preload the counter (bench force) to 0xFFFF_FFFE and observe the wrap to 0.
- Assert rst_main_n low while in W_RESP and R_RESP: bvalid, rvalid and the readies drop asynchronously, and vled=0. After release the readies rise on the first edge.

Source files
------------

// File: rtl/axil_ctrl_regs.sv
// ============================================================================
// Module  : axil_ctrl_regs
// Brief   : AXI-Lite control/status register file (ID, LEDs, DIPs, cycle
//           counter, scratch) terminating the OCL BAR0 channel.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axil_ctrl_regs #(
    parameter int unsigned NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    input  logic [15:0] vdip,
    output logic [15:0] vled
);

    localparam logic [5:0] c_IDX_ID      = 6'd0;
    localparam logic [5:0] c_IDX_VLED    = 6'd1;
    localparam logic [5:0] c_IDX_VDIP    = 6'd2;
    localparam logic [5:0] c_IDX_CYCLE   = 6'd3;
    localparam logic [5:0] c_IDX_CTRL    = 6'd4;
    localparam logic [5:0] c_IDX_SCRATCH = 6'd8;
    localparam logic [1:0] c_OKAY        = 2'b00;
    localparam logic [1:0] c_SLVERR      = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

    w_state_t r_wstate;
    r_state_t r_rstate;

    logic                      r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]                r_bresp, r_rresp;
    logic [31:0]               r_rdata;
    logic                      r_aw_held, r_w_held;
    logic [31:0]               r_awaddr, r_wdata;
    logic [3:0]                r_wstrb;
    logic [15:0]               r_vled, r_vled_out;
    logic [31:0]               r_cycle;
    logic [NUM_SCRATCH*32-1:0] w_scratch_flat;

    // ------------------------------------------------------------------
    // Write-side decode; a held AW/W takes precedence over the live bus
    // ------------------------------------------------------------------
    logic                   w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit;
    logic [31:0]            w_waddr, w_wdat;
    logic [3:0]             w_wstr;
    logic [5:0]             w_widx;
    logic                   w_wupper_ok, w_wscr_range, w_wmapped, w_wsel, w_ctrl_clear;
    logic [NUM_SCRATCH-1:0] w_scr_we;

    assign w_aw_hs   = awvalid & r_awready;
    assign w_w_hs    = wvalid & r_wready;
    assign w_have_aw = r_aw_held | w_aw_hs;
    assign w_have_w  = r_w_held | w_w_hs;
    assign w_commit  = (r_wstate == W_IDLE) & w_have_aw & w_have_w;

    assign w_waddr = r_aw_held ? r_awaddr : awaddr;
    assign w_wdat  = r_w_held ? r_wdata : wdata;
    assign w_wstr  = r_w_held ? r_wstrb : wstrb;
    assign w_widx  = w_waddr[7:2];

    assign w_wupper_ok  = (w_waddr[31:8] == 24'd0);
    assign w_wscr_range = (w_widx >= c_IDX_SCRATCH) &&
                          ({26'd0, w_widx} < (32'd8 + NUM_SCRATCH));
    assign w_wmapped    = w_wupper_ok && ((w_widx <= c_IDX_CTRL) || w_wscr_range);
    assign w_wsel       = w_commit && w_wupper_ok;
    assign w_ctrl_clear = w_wsel && (w_widx == c_IDX_CTRL) && w_wstr[0] && w_wdat[0];

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb;
                    end
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wmapped ? c_OKAY : c_SLVERR;
                    end else begin
                        r_awready <= ~w_have_aw;
                        r_wready  <= ~w_have_w;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= c_OKAY;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_vled     <= 16'd0;
            r_vled_out <= 16'd0;
            r_cycle    <= 32'd0;
        end else begin
            r_vled_out <= r_vled;
            r_cycle    <= w_ctrl_clear ? 32'd0 : r_cycle + 32'd1;
            if (w_wsel && (w_widx == c_IDX_VLED)) begin
                if (w_wstr[0]) r_vled[7:0]  <= w_wdat[7:0];
                if (w_wstr[1]) r_vled[15:8] <= w_wdat[15:8];
            end
        end
    end

    for (genvar g = 0; g < NUM_SCRATCH; g++) begin : g_scratch
        logic [31:0] r_word;

        assign w_scr_we[g] = w_wsel && (w_widx == 6'(8 + g));
        assign w_scratch_flat[32*g +: 32] = r_word;

        always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
            if (!rst_main_n) begin
                r_word <= 32'd0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (w_scr_we[g] && w_wstr[b]) r_word[8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: data is sampled from pre-edge state, so a same-edge write
    // or counter clear is not yet visible in the captured word.
    // ------------------------------------------------------------------
    logic [5:0]  w_ridx;
    logic [31:0] w_rd_data;
    logic        w_rd_ok;

    assign w_ridx = araddr[7:2];

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_ok   = 1'b0;
        if (araddr[31:8] == 24'd0) begin
            case (w_ridx)
                c_IDX_ID:    begin w_rd_data = ID_VALUE;         w_rd_ok = 1'b1; end
                c_IDX_VLED:  begin w_rd_data = {16'h0, r_vled};  w_rd_ok = 1'b1; end
                c_IDX_VDIP:  begin w_rd_data = {16'h0, vdip};    w_rd_ok = 1'b1; end
                c_IDX_CYCLE: begin w_rd_data = r_cycle;          w_rd_ok = 1'b1; end
                c_IDX_CTRL:  begin w_rd_data = 32'd0;            w_rd_ok = 1'b1; end
                default:     ;
            endcase
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_ridx == 6'(c_IDX_SCRATCH + i)) begin
                    w_rd_data = w_scratch_flat[32*i +: 32];
                    w_rd_ok   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= c_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_ok ? c_OKAY : c_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{w_waddr[1:0], araddr[1:0]};

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;
    assign vled    = r_vled_out;

endmodule

`default_nettype wire

// File: tb/tb_axil_ctrl_regs.sv
// ============================================================================
// Module  : tb_axil_ctrl_regs
// Brief   : Directed self-checking bench for axil_ctrl_regs.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_ctrl_regs;

    localparam logic [31:0] c_ID = 32'hC0DE_0001;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] vdip = 16'h5A3C;
    logic [15:0] vled;

    int vec_cnt = 0;
    int err_cnt = 0;
    int tb_cyc  = 0;

    axil_ctrl_regs #(.NUM_SCRATCH(4), .ID_VALUE(c_ID)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
        .vdip(vdip), .vled(vled)
    );

    always #5 clk_main_a0 = ~clk_main_a0;
    always @(posedge clk_main_a0) tb_cyc <= tb_cyc + 1;

    // Bus helpers: all driving and sampling happens on the falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic lat_ok);
        int n;
        logic aw_done, w_done;
        @(negedge clk_main_a0);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(negedge clk_main_a0);
            n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat_ok = bvalid;
        resp   = bvalid ? bresp : 2'bxx;
        if (!(aw_done && w_done)) lat_ok = 1'b0;
        @(negedge clk_main_a0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                           output logic lat_ok, output int hs_cyc);
        int n;
        @(negedge clk_main_a0);
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 20) begin
            @(negedge clk_main_a0);
            n++;
        end
        hs_cyc = tb_cyc + 1;
        @(negedge clk_main_a0);
        arvalid = 1'b0;
        lat_ok  = rvalid && (n < 20);
        data    = rdata;
        resp    = rresp;
        @(negedge clk_main_a0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_main_a0);
        vec_cnt++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            err_cnt++; $display("FAIL reset_hs: got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
        end
        vec_cnt++;
        if ({vled, rdata, bresp, rresp} !== 52'd0) begin
            err_cnt++; $display("FAIL reset_data: vled=%h rdata=%h bresp=%b rresp=%b expected all 0", vled, rdata, bresp, rresp);
        end
        rst_main_n = 1'b1;
        @(posedge clk_main_a0); #1;
        vec_cnt++;
        if ({awready, wready, arready} !== 3'b111) begin
            err_cnt++; $display("FAIL reset_release_ready: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_id_read();
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        do_read(32'h0000_0000, d, r, ok, h);
        vec_cnt++;
        if (ok !== 1'b1 || d !== c_ID || r !== 2'b00) begin
            err_cnt++; $display("FAIL id_read: got lat=%b data=%h resp=%b expected 1 %h 00", ok, d, r, c_ID);
        end
        do_read(32'h0000_0008, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'h0000_5A3C || r !== 2'b00) begin
            err_cnt++; $display("FAIL vdip_read: got %h/%b expected 00005a3c/00", d, r);
        end
    endtask

    task automatic test_vled_write();
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        do_write(32'h0000_0004, 32'h1234_ABCD, 4'b0011, r, ok);
        vec_cnt++;
        if (ok !== 1'b1 || r !== 2'b00) begin
            err_cnt++; $display("FAIL vled_bresp: got lat=%b resp=%b expected 1 00", ok, r);
        end
        vec_cnt++;
        if (vled !== 16'hABCD) begin
            err_cnt++; $display("FAIL vled_out: got %h expected abcd", vled);
        end
        do_read(32'h0000_0004, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'h0000_ABCD || r !== 2'b00) begin
            err_cnt++; $display("FAIL vled_readback: got %h/%b expected 0000abcd/00", d, r);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        @(negedge clk_main_a0);
        bready = 1'b0; awaddr = 32'h0000_0020; awvalid = 1'b1;
        vec_cnt++;
        if (awready !== 1'b1) begin
            err_cnt++; $display("FAIL split_aw_ready: got %b expected 1", awready);
        end
        @(negedge clk_main_a0);
        awvalid = 1'b0;
        vec_cnt++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            err_cnt++; $display("FAIL split_aw_drop: got aw=%b w=%b expected 0 1", awready, wready);
        end
        repeat (2) @(negedge clk_main_a0);
        vec_cnt++;
        if (awready !== 1'b0 || bvalid !== 1'b0) begin
            err_cnt++; $display("FAIL split_wait: got aw=%b b=%b expected 0 0", awready, bvalid);
        end
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk_main_a0);
        wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                err_cnt++; $display("FAIL split_bhold%0d: got b/aw/w=%b expected 100", k, {bvalid, awready, wready});
            end
            @(negedge clk_main_a0);
        end
        bready = 1'b1;
        @(negedge clk_main_a0);
        vec_cnt++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            err_cnt++; $display("FAIL split_release: got b/aw/w=%b expected 011", {bvalid, awready, wready});
        end
        do_read(32'h0000_0020, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'hDEAD_BEEF) begin
            err_cnt++; $display("FAIL split_readback: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_strobe_unmapped();
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        do_write(32'h0000_0024, 32'hFFFF_FFFF, 4'b0101, r, ok);
        do_read(32'h0000_0024, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'h00FF_00FF || r !== 2'b00) begin
            err_cnt++; $display("FAIL scratch_strb: got %h/%b expected 00ff00ff/00", d, r);
        end
        do_read(32'h0000_003C, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'd0 || r !== 2'b10) begin
            err_cnt++; $display("FAIL unmapped_read: got %h/%b expected 00000000/10", d, r);
        end
        do_read(32'h0000_0100, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'd0 || r !== 2'b10) begin
            err_cnt++; $display("FAIL upper_addr_read: got %h/%b expected 00000000/10", d, r);
        end
        do_write(32'h0000_0120, 32'h0BAD_0BAD, 4'hF, r, ok);
        vec_cnt++;
        if (r !== 2'b10) begin
            err_cnt++; $display("FAIL unmapped_write: got resp=%b expected 10", r);
        end
        do_write(32'h0000_0000, 32'h0BAD_0BAD, 4'hF, r, ok);
        do_read(32'h0000_0000, d, r, ok, h);
        vec_cnt++;
        if (d !== c_ID || r !== 2'b00) begin
            err_cnt++; $display("FAIL ro_write: got %h/%b expected %h/00", d, r, c_ID);
        end
        do_read(32'h0000_0020, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'hDEAD_BEEF) begin
            err_cnt++; $display("FAIL unmapped_no_effect: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] v1, v2, v3; logic [1:0] r; logic ok; int h1, h2;
        logic [31:0] prev, cur; logic seen;
        do_read(32'h0000_000C, v1, r, ok, h1);
        repeat (7) @(negedge clk_main_a0);
        do_read(32'h0000_000C, v2, r, ok, h2);
        vec_cnt++;
        if (h2 - h1 != 10 || v2 - v1 !== 32'(h2 - h1)) begin
            err_cnt++; $display("FAIL cycle_delta: got %0d expected %0d", v2 - v1, h2 - h1);
        end
        do_write(32'h0000_0010, 32'h0000_0001, 4'b0010, r, ok);
        do_read(32'h0000_000C, v3, r, ok, h1);
        vec_cnt++;
        if (v3 <= v2) begin
            err_cnt++; $display("FAIL ctrl_strb_ignored: got %h expected above %h", v3, v2);
        end
        do_write(32'h0000_0010, 32'h0000_0001, 4'b0001, r, ok);
        do_read(32'h0000_000C, v3, r, ok, h1);
        vec_cnt++;
        if (v3 >= 32'd5) begin
            err_cnt++; $display("FAIL ctrl_clear: got %h expected below 5", v3);
        end
        do_read(32'h0000_0010, v3, r, ok, h1);
        vec_cnt++;
        if (v3 !== 32'd0 || r !== 2'b00) begin
            err_cnt++; $display("FAIL ctrl_read: got %h/%b expected 00000000/00", v3, r);
        end
        @(negedge clk_main_a0);
        force dut.r_cycle = 32'hFFFF_FFFE;
        @(negedge clk_main_a0);
        release dut.r_cycle;
        prev = dut.r_cycle; seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_main_a0);
            cur = dut.r_cycle;
            if (prev == 32'hFFFF_FFFF && cur == 32'd0) seen = 1'b1;
            prev = cur;
        end
        vec_cnt++;
        if (seen !== 1'b1) begin
            err_cnt++; $display("FAIL cycle_wrap: got no ffffffff->0 step, last value %h", prev);
        end
    endtask

    task automatic test_back_to_back();
        int hs[2]; logic [31:0] rd[2]; int cnt, got;
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        @(negedge clk_main_a0);
        awaddr = 32'h28; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        cnt = 0;
        for (int n = 0; n < 20 && cnt < 2; n++) begin
            if (awready && wready) begin hs[cnt] = tb_cyc + 1; cnt++; end
            @(negedge clk_main_a0);
            if (cnt == 1) begin awaddr = 32'h2C; wdata = 32'h5A5A_0002; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        vec_cnt++;
        if (cnt != 2 || hs[1] - hs[0] != 2) begin
            err_cnt++; $display("FAIL b2b_write_spacing: got count=%0d gap=%0d expected 2 2", cnt, hs[1] - hs[0]);
        end
        repeat (2) @(negedge clk_main_a0);
        araddr = 32'h28; arvalid = 1'b1; rready = 1'b1; cnt = 0; got = 0;
        for (int n = 0; n < 20 && got < 2; n++) begin
            if (rvalid) begin rd[got] = rdata; got++; end
            if (arvalid && arready) begin hs[cnt] = tb_cyc + 1; cnt++; end
            @(negedge clk_main_a0);
            if (cnt == 1) araddr = 32'h2C;
            if (cnt == 2) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        vec_cnt++;
        if (got != 2 || hs[1] - hs[0] != 2 || rd[0] !== 32'hA5A5_0001 || rd[1] !== 32'h5A5A_0002) begin
            err_cnt++; $display("FAIL b2b_read: got n=%0d gap=%0d %h %h expected 2 2 a5a50001 5a5a0002",
                                got, hs[1] - hs[0], rd[0], rd[1]);
        end
        do_write(32'h2C, 32'h1111_1111, 4'hF, r, ok);
        @(negedge clk_main_a0);
        awaddr = 32'h2C; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 32'h2C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        vec_cnt++;
        if ({awready, wready, arready} !== 3'b111) begin
            err_cnt++; $display("FAIL same_edge_ready: got %b expected 111", {awready, wready, arready});
        end
        @(negedge clk_main_a0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        vec_cnt++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h1111_1111) begin
            err_cnt++; $display("FAIL same_edge_old: got r=%b b=%b data=%h expected 1 1 11111111", rvalid, bvalid, rdata);
        end
        @(negedge clk_main_a0);
        do_read(32'h2C, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'h2222_2222) begin
            err_cnt++; $display("FAIL same_edge_new: got %h expected 22222222", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; logic ok; int h;
        @(negedge clk_main_a0);
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h24; wdata = 32'h7777_7777; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk_main_a0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        vec_cnt++;
        if ({bvalid, rvalid} !== 2'b11 || vled !== 16'hABCD) begin
            err_cnt++; $display("FAIL mid_pre: got b/r=%b vled=%h expected 11 abcd", {bvalid, rvalid}, vled);
        end
        #2 rst_main_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 || vled !== 16'h0) begin
            err_cnt++; $display("FAIL mid_async: got %b vled=%h expected 00000 0000",
                                {bvalid, rvalid, awready, wready, arready}, vled);
        end
        @(negedge clk_main_a0);
        bready = 1'b1; rready = 1'b1; rst_main_n = 1'b1;
        @(posedge clk_main_a0); #1;
        vec_cnt++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            err_cnt++; $display("FAIL mid_release: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
        end
        do_read(32'h24, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'd0) begin
            err_cnt++; $display("FAIL mid_scratch: got %h expected 00000000", d);
        end
        do_read(32'h04, d, r, ok, h);
        vec_cnt++;
        if (d !== 32'd0) begin
            err_cnt++; $display("FAIL mid_vled_reg: got %h expected 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_vled_write();
        test_split_write();
        test_strobe_unmapped();
        test_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
